// File: rtl/cipher_byte_stage.sv
// Byte FIFO between uart_rx and uart_tx; each popped byte is XORed with a
// 16-bit Galois LFSR keystream when CIPHER_KEYSTREAM_EN is defined, else passed through.
module cipher_byte_stage #(
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [15:0] LFSR_TAPS    = 16'hB400,
  parameter int          BUSY_TIMEOUT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        key_load,
  input  logic [15:0] key_in,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        fifo_empty,
  output logic        fifo_full,
  output logic        overflow,
  output logic [15:0] byte_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LAST  = TW'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE} state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] to_cnt;
  logic          pop, push;
  logic [7:0]    head, cipher;

  assign pop  = (state == IDLE) && !fifo_empty;
  // A full FIFO still accepts a byte in the same cycle a pop frees a slot.
  assign push = in_valid && (!fifo_full || pop);
  assign head = mem[rd_ptr];

`ifdef CIPHER_KEYSTREAM_EN
  logic [15:0] lfsr;

  assign cipher = head ^ lfsr[7:0];

  // Key load overrides the step; zero maps to the seed so the LFSR never locks up.
  always_ff @(posedge clk) begin
    if (rst)
      lfsr <= LFSR_SEED;
    else if (key_load)
      lfsr <= (key_in == 16'h0000) ? LFSR_SEED : key_in;
    else if (pop)
      lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
  end
`else
  logic unused_key;

  assign cipher     = head;
  assign unused_key = ^{key_load, key_in, LFSR_SEED, LFSR_TAPS};
`endif

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (in_valid && fifo_full && !pop)
        overflow <= 1'b1;
      case ({push, pop})
        2'b10: begin
          count      <= count + 1'b1;
          fifo_empty <= 1'b0;
          fifo_full  <= (count == FULL_CNT - 1'b1);
        end
        2'b01: begin
          count      <= count - 1'b1;
          fifo_full  <= 1'b0;
          fifo_empty <= (count == CW'(1));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_data    <= 8'h00;
      tx_start   <= 1'b0;
      byte_count <= 16'h0000;
      to_cnt     <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data  <= cipher;
            tx_start <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          byte_count <= byte_count + 16'd1;
          to_cnt     <= '0;
          state      <= WAIT_BUSY;
        end
        // No busy response within the window: the byte is treated as lost.
        WAIT_BUSY: begin
          if (tx_busy)
            state <= WAIT_IDLE;
          else if (to_cnt == TO_LAST)
            state <= IDLE;
          else
            to_cnt <= to_cnt + 1'b1;
        end
        WAIT_IDLE: begin
          if (!tx_busy)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cipher_byte_stage.sv
// Directed bench for cipher_byte_stage: vector table for cipher/keystream
// results plus hand sequences for overflow, full push/pop, timeout and reset.
module tb_cipher_byte_stage;

`ifdef CIPHER_KEYSTREAM_EN
  localparam bit KS = 1'b1;
`else
  localparam bit KS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        key_load;
  logic [15:0] key_in;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        fifo_empty;
  logic        fifo_full;
  logic        overflow;
  logic [15:0] byte_count;

  cipher_byte_stage dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .key_load(key_load), .key_in(key_in), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_start(tx_start), .fifo_empty(fifo_empty),
    .fifo_full(fifo_full), .overflow(overflow), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  // uart_tx stand-in: 0 = busy for 3 cycles after each start, 1 = stuck high, 2 = never busy
  int         busy_mode = 0;
  int         busy_left = 0;
  logic [7:0] launched [$];

  always @(posedge clk) begin
    if (busy_left > 0) busy_left <= busy_left - 1;
    if (tx_start && busy_mode == 0) busy_left <= 3;
    if (tx_start) launched.push_back(tx_data);
  end

  assign tx_busy = (busy_mode == 1) || (busy_mode == 0 && busy_left != 0);

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [7:0] enc(input logic [7:0] d, input logic [7:0] k);
    return KS ? (d ^ k) : d;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] d);
    in_data = d; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  din;
    logic        kload;
    logic [15:0] key;
    logic [7:0]  exp;
  } vec_t;

  vec_t vecs [7];
  logic [7:0] exp_q [$];
  int starts;

  initial begin
    // LFSR chain from seed: ACE1 -> E270 -> 7138; key 0001 -> B400; key 0 -> ACE1 ...
    vecs[0] = '{8'h41, 1'b0, 16'h0000, enc(8'h41, 8'hE1)};
    vecs[1] = '{8'h41, 1'b0, 16'h0000, enc(8'h41, 8'h70)};
    vecs[2] = '{8'h00, 1'b1, 16'h0001, enc(8'h00, 8'h01)};
    vecs[3] = '{8'h41, 1'b1, 16'h0000, enc(8'h41, 8'hE1)};
    vecs[4] = '{8'h41, 1'b0, 16'h0000, enc(8'h41, 8'h70)};
    vecs[5] = '{8'hFF, 1'b0, 16'h0000, enc(8'hFF, 8'h38)};
    vecs[6] = '{8'h00, 1'b0, 16'h0000, enc(8'h00, 8'h9C)};

    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; key_load = 1'b0; key_in = 16'h0000;
    do_reset();
    chk("rst tx_data", {24'h0, tx_data}, 32'h0);
    chk("rst tx_start", {31'h0, tx_start}, 32'h0);
    chk("rst overflow", {31'h0, overflow}, 32'h0);
    chk("rst byte_count", {16'h0, byte_count}, 32'h0);
    chk("rst fifo_empty", {31'h0, fifo_empty}, 32'h1);
    chk("rst fifo_full", {31'h0, fifo_full}, 32'h0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].kload) begin
        key_load = 1'b1; key_in = vecs[i].key;
        step();
        key_load = 1'b0;
      end
      push(vecs[i].din);
      chk($sformatf("vec%0d no early start", i), {31'h0, tx_start}, 32'h0);
      step();
      chk($sformatf("vec%0d tx_start n+2", i), {31'h0, tx_start}, 32'h1);
      chk($sformatf("vec%0d tx_data", i), {24'h0, tx_data}, {24'h0, vecs[i].exp});
      step();
      chk($sformatf("vec%0d start one cycle", i), {31'h0, tx_start}, 32'h0);
      repeat (7) step();
      chk($sformatf("vec%0d byte_count", i), {16'h0, byte_count}, i + 1);
      chk($sformatf("vec%0d tx_data held", i), {24'h0, tx_data}, {24'h0, vecs[i].exp});
    end

    // Key load in the pop cycle: XOR uses old LFSR (1C4E), then load wins (1234).
    push(8'h00);
    key_load = 1'b1; key_in = 16'h1234;
    step();
    key_load = 1'b0;
    chk("keypop tx_data old lfsr", {24'h0, tx_data}, {24'h0, enc(8'h00, 8'h4E)});
    repeat (8) step();
    push(8'h00);
    step();
    chk("keypop tx_data new key", {24'h0, tx_data}, {24'h0, enc(8'h00, 8'h34)});
    repeat (8) step();

    // Fill while uart_tx is stuck busy; then simultaneous push/pop at full; then overflow.
    do_reset();
    launched.delete();
    busy_mode = 1;
    for (int i = 0; i < 5; i++) begin
      push(8'h10 + 8'(i));
      chk($sformatf("fill%0d fifo_full", i), {31'h0, fifo_full}, (i == 4) ? 32'h1 : 32'h0);
    end
    chk("fill overflow clear", {31'h0, overflow}, 32'h0);
    busy_mode = 0;
    step();
    push(8'h15);
    chk("full push+pop tx_start", {31'h0, tx_start}, 32'h1);
    chk("full push+pop tx_data", {24'h0, tx_data}, {24'h0, enc(8'h11, 8'h70)});
    chk("full push+pop fifo_full", {31'h0, fifo_full}, 32'h1);
    chk("full push+pop no overflow", {31'h0, overflow}, 32'h0);
    busy_mode = 1;
    push(8'h16);
    chk("drop overflow", {31'h0, overflow}, 32'h1);
    chk("drop fifo_full", {31'h0, fifo_full}, 32'h1);
    busy_mode = 0;
    for (int t = 0; t < 200 && launched.size() < 6; t++) step();
    chk("drain launch count", launched.size(), 32'd6);
    exp_q = '{enc(8'h10, 8'hE1), enc(8'h11, 8'h70), enc(8'h12, 8'h38),
              enc(8'h13, 8'h9C), enc(8'h14, 8'h4E), enc(8'h15, 8'h27)};
    for (int i = 0; i < 6 && i < launched.size(); i++)
      chk($sformatf("drain byte%0d", i), {24'h0, launched[i]}, {24'h0, exp_q[i]});
    repeat (8) step();
    chk("drain fifo_empty", {31'h0, fifo_empty}, 32'h1);
    chk("drain byte_count", {16'h0, byte_count}, 32'd6);
    chk("drain overflow sticky", {31'h0, overflow}, 32'h1);

    // tx_busy never rises: timeout back to IDLE, then next byte launches.
    do_reset();
    busy_mode = 2;
    push(8'h41);
    push(8'h42);
    chk("timeout first start", {31'h0, tx_start}, 32'h1);
    chk("timeout first data", {24'h0, tx_data}, {24'h0, enc(8'h41, 8'hE1)});
    starts = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (tx_start) starts++;
    end
    chk("timeout no early relaunch", starts, 32'd0);
    step();
    chk("timeout second start", {31'h0, tx_start}, 32'h1);
    chk("timeout second data", {24'h0, tx_data}, {24'h0, enc(8'h42, 8'h70)});

    // Reset while in WAIT_IDLE with a byte still buffered.
    busy_mode = 1;
    step();
    chk("timeout byte_count", {16'h0, byte_count}, 32'd2);
    step();
    push(8'h55);
    chk("pre-rst fifo_empty", {31'h0, fifo_empty}, 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    busy_mode = 0;
    chk("midrst tx_data", {24'h0, tx_data}, 32'h0);
    chk("midrst tx_start", {31'h0, tx_start}, 32'h0);
    chk("midrst byte_count", {16'h0, byte_count}, 32'h0);
    chk("midrst fifo_empty", {31'h0, fifo_empty}, 32'h1);
    chk("midrst fifo_full", {31'h0, fifo_full}, 32'h0);
    chk("midrst overflow", {31'h0, overflow}, 32'h0);
    starts = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (tx_start) starts++;
    end
    chk("midrst fifo flushed", starts, 32'd0);
    push(8'h41);
    step();
    chk("post-rst start", {31'h0, tx_start}, 32'h1);
    chk("post-rst seed data", {24'h0, tx_data}, {24'h0, enc(8'h41, 8'hE1)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cipher_byte_stage.md
# cipher_byte_stage

- Sits between `uart_rx` and `uart_tx`; replaces the direct rx→tx loopback.
- Buffers received bytes in a small FIFO and XORs each byte with a 16-bit LFSR keystream.
- Launches `uart_tx` one byte at a time, pacing launches on `tx_busy`.
- XOR is symmetric, so the same block encrypts and decrypts with a shared key.

## Interface
- `FIFO_DEPTH`, 4: FIFO entries; power of two, ≥2.
- `LFSR_SEED`, 16'hACE1: LFSR value after reset, and on a key load of zero.
- `LFSR_TAPS`, 16'hB400: Galois tap mask (x^16+x^14+x^13+x^11+1).
- `BUSY_TIMEOUT`, 4: cycles to wait for `tx_busy` to rise after a launch.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  8  received byte (from `uart_rx.rx_data`).
- `in_valid`  in  1  one-cycle strobe: `in_data` valid this cycle.
- `key_load`  in  1  one-cycle strobe: load `key_in` into the LFSR.
- `key_in`  in  16  key value.
- `tx_busy`  in  1  busy flag from `uart_tx`.
- `tx_data`  out  8  ciphered byte to `uart_tx`.
- `tx_start`  out  1  one-cycle launch pulse to `uart_tx`.
- `fifo_empty`  out  1  FIFO holds no bytes.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `overflow`  out  1  sticky: an input byte was dropped.
- `byte_count`  out  16  bytes launched; wraps modulo 2^16.

## Operation
- **Reset values** (`rst`=1 at a clock edge):
  - `tx_data`=0, `tx_start`=0, `overflow`=0, `byte_count`=0.
  - `fifo_empty`=1, `fifo_full`=0, FIFO pointers=0.
  - LFSR=`LFSR_SEED`, FSM=IDLE.
  - `rst` mid-frame abandons the current byte and flushes the FIFO.
- **Push:** `in_valid` writes `in_data` at the tail.
  - If full and no pop that cycle: byte dropped, `overflow` set (cleared only by `rst`).
  - If full with a simultaneous pop: the push is accepted and occupancy stays full.
- **Pop and cipher:** a pop occurs only in IDLE with FIFO non-empty.
  - `tx_data` ← head ^ LFSR[7:0].
  - The LFSR then steps once: lsb=1 → (lfsr>>1)^`LFSR_TAPS`, else lfsr>>1.
- **Key load:**
  - `key_load` sets LFSR ← `key_in`; if `key_in`=0, LFSR ← `LFSR_SEED` (no lockup state).
  - If `key_load` coincides with a pop: the XOR uses the old LFSR, and the load wins over the step.
  - The FIFO is not flushed.
- **FSM:**
  - IDLE: if FIFO non-empty, pop, register `tx_data` → LAUNCH.
  - LAUNCH: `tx_start`=1 for exactly this cycle; `byte_count`+1 → WAIT_BUSY.
  - WAIT_BUSY: `tx_busy`=1 → WAIT_IDLE; after `BUSY_TIMEOUT` cycles without it → IDLE (byte considered lost).
  - WAIT_IDLE: `tx_busy`=0 → IDLE.
- `tx_data` is held stable from LAUNCH until the next pop.

## Timing
- `in_valid` at cycle n, FSM IDLE → `tx_start` high in cycle n+2.
- Back-to-back bytes: next `tx_start` no earlier than 2 cycles after `tx_busy` falls.
- `fifo_empty` and `fifo_full` are registered and reflect the push/pop of the previous edge.
- Pushes accepted every cycle; each byte is 8 bits, with no width growth.
- `byte_count` wraps 16'hFFFF→16'h0000.

## Configuration
- `CIPHER_KEYSTREAM_EN` defined:
  - LFSR present; XOR applied as described.
  - `key_load` and `key_in` are active.
- `CIPHER_KEYSTREAM_EN` undefined:
  - LFSR omitted; `tx_data` = head byte unchanged.
  - `key_load` and `key_in` are ignored.
  - All FIFO, FSM and timing behaviour is identical.

## Test plan
- Reset, then `in_data`=8'h41 strobe, `tx_busy` modelled to rise 1 cycle after start → `tx_start` at n+2, `tx_data`=8'hA0, `byte_count`=1.
- Second 8'h41 after tx idle → `tx_data`=8'h31 (LFSR was 16'hE270).
- `key_load` with `key_in`=16'h0001, then byte 8'h00 → `tx_data`=8'h01; `key_load` with `key_in`=0, then byte 8'h41 → 8'hA0.
- `tx_busy` held high; push 5 bytes with `FIFO_DEPTH`=4 → first byte launched and stuck in WAIT_IDLE; after 4 bytes, `fifo_full`=1; 6th push sets `overflow`=1.
- Bytes buffered, release `tx_busy` → remaining bytes launched in order, one `tx_start` per busy low; full-plus-simultaneous push/pop keeps `fifo_full`=1 with no overflow.
- `tx_busy` never asserts → FSM returns to IDLE after 4 cycles and launches the next byte; `rst` asserted in WAIT_IDLE → all outputs return to reset values the next cycle.
- Build without `CIPHER_KEYSTREAM_EN` → 8'h41 in gives 8'h41 out.
